// File: rtl/hbm_dma_fetch.sv
// hbm_dma_fetch: fetches a host buffer into the HBM clock domain.
// The transfer is split into DMA read commands of at most MAX_CMD_BYTES.
// Returned 512-bit beats are buffered in a first-word-fall-through FIFO and
// forwarded as a valid-only stream, throttled by the consumer's almost_full.
// A command is only issued when the FIFO has room for every beat already
// in flight plus the new command, so returned data can always be accepted.
module hbm_dma_fetch #(
  parameter int MAX_CMD_BYTES = 4096,
  parameter int FIFO_DEPTH    = 512
) (
  input  logic         hbm_clk,
  input  logic         hbm_rst,
  output logic         m_axis_dma_read_cmd_valid,
  input  logic         m_axis_dma_read_cmd_ready,
  output logic [63:0]  m_axis_dma_read_cmd_address,
  output logic [31:0]  m_axis_dma_read_cmd_length,
  input  logic         s_axis_dma_read_data_valid,
  output logic         s_axis_dma_read_data_ready,
  input  logic [511:0] s_axis_dma_read_data_data,
  input  logic [63:0]  s_axis_dma_read_data_keep,
  input  logic         s_axis_dma_read_data_last,
  input  logic         start,
  input  logic [63:0]  addr_x,
  input  logic [31:0]  data_length,
  output logic [511:0] out_data,
  output logic         out_valid,
  input  logic         out_almost_full,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [63:0]        cur_addr_q;
  logic [31:0]        total_q;
  logic [31:0]        remaining_q;
  logic [31:0]        received_q;
  logic [31:0]        chunk_q;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               almost_full_q;
  logic [511:0]       out_data_q;
  logic               out_valid_q;
  logic [511:0]       fifo_mem [FIFO_DEPTH];

  logic               start_accept;
  logic               fifo_full, fifo_empty;
  logic               beat_wr, fifo_rd, cmd_hs;
  logic [31:0]        chunk_w, chunk_beats_w, credit_w;
  logic               credit_ok, drain_done;

  // keep and last carry no information for this block
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_dma_read_data_keep, s_axis_dma_read_data_last};

  assign fifo_full     = (fifo_count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_count_q == '0);
  assign start_accept  = start & ~busy;
  // Beats arriving while idle are stale (e.g. after a reset) and are dropped.
  assign beat_wr       = s_axis_dma_read_data_valid & ~fifo_full & (state_q != ST_IDLE);
  assign fifo_rd       = ~fifo_empty & ~almost_full_q;
  assign cmd_hs        = (state_q == ST_ISSUE) & m_axis_dma_read_cmd_ready;
  assign chunk_w       = (remaining_q > 32'(MAX_CMD_BYTES)) ? 32'(MAX_CMD_BYTES) : remaining_q;
  assign chunk_beats_w = chunk_w >> 6;
  assign credit_w      = 32'(fifo_count_q) + 32'(outstanding_q) + chunk_beats_w;
  assign credit_ok     = (credit_w <= 32'(FIFO_DEPTH));
  assign drain_done    = (received_q == total_q);

  assign s_axis_dma_read_data_ready  = ~fifo_full;
  assign m_axis_dma_read_cmd_address = cur_addr_q;
  assign m_axis_dma_read_cmd_length  = chunk_q;
  assign out_data                    = out_data_q;
  assign out_valid                   = out_valid_q;

  // State register.
  always_ff @(posedge hbm_clk) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (hbm_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_d                   = state_q;
    m_axis_dma_read_cmd_valid = 1'b0;
    busy                      = 1'b1;
    done                      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (remaining_q == '0) state_d = ST_DRAIN;
        else if (credit_ok)    state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        m_axis_dma_read_cmd_valid = 1'b1;
        if (m_axis_dma_read_cmd_ready) state_d = ST_CHECK;
      end
      ST_DRAIN: begin
        if (drain_done) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter next-state: a command handshake and a beat may land together.
  always_comb begin
    outstanding_d = outstanding_q;
    if (cmd_hs)  outstanding_d = outstanding_d + chunk_q[CNT_W+5:6];
    if (beat_wr) outstanding_d = outstanding_d - CNT_W'(1);
    fifo_count_d = fifo_count_q;
    if (beat_wr) fifo_count_d = fifo_count_d + CNT_W'(1);
    if (fifo_rd) fifo_count_d = fifo_count_d - CNT_W'(1);
  end

  // Transfer bookkeeping: start capture, address/remaining/received counters.
  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      start_q       <= 1'b0;
      cur_addr_q    <= '0;
      total_q       <= '0;
      remaining_q   <= '0;
      received_q    <= '0;
      chunk_q       <= '0;
      outstanding_q <= '0;
    end else begin
      start_q       <= start_accept;
      outstanding_q <= outstanding_d;
      if (start_accept) begin
        cur_addr_q  <= addr_x;
        total_q     <= data_length & 32'hFFFF_FFC0;
        remaining_q <= data_length & 32'hFFFF_FFC0;
        received_q  <= '0;
      end
      if (state_q == ST_CHECK && state_d == ST_ISSUE) chunk_q <= chunk_w;
      if (cmd_hs) begin
        cur_addr_q  <= cur_addr_q + 64'(chunk_q);
        remaining_q <= remaining_q - chunk_q;
      end
      if (beat_wr) received_q <= received_q + 32'd64;
    end
  end

  // FIFO pointers and occupancy; reset flushes the FIFO.
  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      if (beat_wr) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (fifo_rd) rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage write.
  always_ff @(posedge hbm_clk) begin
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing them is enough to flush.
    if (beat_wr) fifo_mem[wr_ptr_q] <= s_axis_dma_read_data_data;
  end

  // Output stage: registered almost_full and registered read data.
  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      almost_full_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      almost_full_q <= out_almost_full;
      out_valid_q   <= fifo_rd;
      if (fifo_rd) out_data_q <= fifo_mem[rd_ptr_q];
    end
  end

endmodule
